// File: rtl/cpu_regfile_rd.sv
// 32x32 register file with two registered read ports, write-through bypass and a load-pending scoreboard.
// One-cycle read latency; a read of a register awaiting a load is refused (hazard) and its outputs hold.
module cpu_regfile_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0] d,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mn,
  input  logic              re,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              rvalid,
  output logic              hazard
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic              wr_ok;
  logic              epa;
  logic              epb;
  logic              accept;
  logic [DATA_W-1:0] rda;
  logic [DATA_W-1:0] rdb;

  assign wr_ok = we && (wn != '0);

  // A write retiring in this same cycle resolves the pending load.
  assign epa    = pend[rna] && !(we && (wn == rna));
  assign epb    = pend[rnb] && !(we && (wn == rnb));
  assign hazard = re && (epa || epb);
  assign accept = re && !hazard;

  always_comb begin
    rda = '0;
    rdb = '0;
    if (rna != '0) rda = (wr_ok && (wn == rna)) ? d : regs[rna];
    if (rnb != '0) rdb = (wr_ok && (wn == rnb)) ? d : regs[rnb];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pend   <= '0;
      qa     <= '0;
      qb     <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[wn] <= d;
        pend[wn] <= 1'b0;
      end
      // Mark placed after the clear so a newly issued load wins over the retiring write.
      if (mark && (mn != '0)) pend[mn] <= 1'b1;
      rvalid <= accept;
      if (accept) begin
        qa <= rda;
        qb <= rdb;
      end
    end
  end

endmodule

// File: doc/cpu_regfile_rd.md
Name: cpu_regfile_rd

Overview:
- 32 x 32-bit CPU general-purpose register file, write-side storage paired with the read side used by the decode stage.
- Two registered read ports with write-through bypass, and a load-pending scoreboard that blocks reads of registers awaiting a load result.
- Sits between the writeback stage (write port, scoreboard clear) and the decode stage (read ports, hazard flag). Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
- Clk  in  1  rising-edge clock, sole clock domain
- Clr  in  1  synchronous reset, active-high
- We  in  1  write enable
- Wn  in  ADDR_W  write register index
- D  in  DATA_W  write data
- Mark  in  1  set pending bit for Mn (load issued)
- Mn  in  ADDR_W  register index to mark pending
- Re  in  1  read request
- Rna  in  ADDR_W  read port A index
- Rnb  in  ADDR_W  read port B index
- Qa  out  DATA_W  port A data, registered
- Qb  out  DATA_W  port B data, registered
- Rvalid  out  1  pulses one cycle after an accepted read
- Hazard  out  1  combinational; read request blocked this cycle

Behaviour:
- The reset is synchronous and active-high. With Clr=1 at a rising Clk edge, the following clear together: all registers, the pending vector, Qa, Qb and Rvalid all go to 0. Clr has priority over all other inputs, including mid-read or mid-write. Hazard then evaluates as 0.
- Write: at the edge, if We=1 and Wn!=0, reg[Wn] is set to D. A write with Wn=0 is ignored.
- Pending vector, one bit per register:
  - Mark=1 with Mn!=0 sets pend[Mn].
  - We=1 with Wn!=0 clears pend[Wn].
  - Same cycle, Mn==Wn: the set wins and the bit ends at 1 (a new load was issued after the retiring write).
  - pend[0] is always 0.
- Effective pending for hazard: epa = pend[Rna] & ~(We & Wn==Rna). epb is defined the same way for Rnb. A write in the same cycle resolves the pending bit.
- Hazard = Re & (epa | epb). It is 0 whenever Re=0.
- Read acceptance: the read is accepted when Re=1 and Hazard=0.
  - At the edge, Qa and Qb load the selected values and Rvalid goes to 1.
  - Latency: 1 cycle from request to data.
- Read value per port:
  - Index 0 gives 0.
  - If We=1 and Wn equals the index (nonzero), the value is D (same-cycle bypass).
  - Otherwise the value is reg[index].
  - Rna==Rnb is legal; both ports return the same value.
- Not accepted (Re=0 or Hazard=1): Qa and Qb hold their previous values, and Rvalid goes to 0 at the edge.
- Rvalid is a single-cycle pulse per accepted read. Back-to-back accepted reads keep Rvalid high.
- A Mark in the same cycle as a read of Mn does not affect that read's hazard. It only takes effect from the next cycle.
- No other state. Storage is a plain 32-entry array with no initial-value dependence beyond reset.

Test Plan:
- Reset then read: Clr=1 for 1 cycle, then Re=1, Rna=5, Rnb=31 -> next cycle Qa=0, Qb=0, Rvalid=1, Hazard=0 throughout.
- Write then read: We=1, Wn=3, D=32'h0F0F0F0F. Next cycle Re=1, Rna=3, Rnb=0 -> Qa=32'h0F0F0F0F, Qb=0, Rvalid=1. A write with Wn=0, D=32'hFFFFFFFF followed by a read of 0 -> Qa=0.
- Bypass: same cycle We=1, Wn=7, D=32'hF0F0F0F0, Re=1, Rna=7, Rnb=7 -> next cycle Qa=Qb=32'hF0F0F0F0 (reg[7] previously 0).
- Scoreboard block/release:
  - Mark=1, Mn=9 at cycle n.
  - Cycle n+1: Re=1, Rnb=9 -> Hazard=1; next cycle Rvalid=0, Qa/Qb unchanged.
  - Cycle n+2: We=1, Wn=9, D=32'h33333333 with Re=1, Rnb=9 -> Hazard=0; next cycle Qb=32'h33333333, Rvalid=1.
- Simultaneous mark/write: Mark=1, Mn=4 and We=1, Wn=4, D=32'hCCCCCCCC -> reg[4]=32'hCCCCCCCC, pend[4]=1. Next cycle read of 4 -> Hazard=1.
- Reset mid-operation: with pend[12]=1 and reg[12]=32'h12345678, assert Clr together with Re=1, Rna=12 -> next cycle Qa=0, Rvalid=0. A following read of 12 -> Hazard=0, Qa=0.
